burst_rr_arbiter: RTL
=====================

# burst_rr_arbiter

Round-robin arbiter for N requesters sharing one multi-cycle resource, such as a shared bus port or memory channel. A grant is held for a whole transaction and released on the owner's `done`, on the owner dropping its request, or optionally on a hold timeout. Fairness comes from a rotating priority pointer that moves past each requester once it has been served. The block sits between requester FSMs and the shared resource mux, which it steers through `gnt_id`.

## Interface
- `N`, default 4: number of requesters, 2..16.
- `MAX_HOLD`, default 16: maximum cycles a grant may be held when the timeout is compiled in; must be ≥1.
- `IDW`, default `$clog2(N)`: width of `gnt_id`. Derived; do not override.
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `req`  in  N  per-requester request, level; held high for the whole transaction.
- `done`  in  N  per-requester end-of-transaction strobe; sampled only for the current owner.
- `gnt`  out  N  one-hot registered grant; all-zero when idle.
- `gnt_id`  out  IDW  binary index of the owner; valid only while `busy`=1.
- `busy`  out  1  equals `|gnt`.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- The FSM has two states: IDLE and BUSY.
- The block keeps a pointer `ptr` (IDW bits) and a hold counter `hold_cnt` of width `$clog2(MAX_HOLD+1)`.
- In IDLE with `req`≠0, the arbiter searches `req` starting at index `ptr` and moves upward, wrapping from N-1 to 0. The first set bit is the winner.
- On that edge: `gnt` is set to the one-hot winner, `gnt_id` to the winner's index, `hold_cnt` to 1, and the state goes to BUSY.
- In IDLE with `req`=0, the state stays IDLE and `gnt` stays 0.
- In BUSY, release happens when any of these holds for the owner o:
  - `done[o]`=1;
  - `req[o]`=0;
  - with the timeout compiled in, `hold_cnt`==MAX_HOLD.
- On release: `gnt` goes to 0, the state goes to IDLE, and `ptr` becomes (o+1) mod N. For non-power-of-two N the wrap is an explicit compare, not a bit-width overflow.
- In BUSY without release, `hold_cnt` increments and saturates at MAX_HOLD.
- `done` and `req` changes on non-owners are ignored while BUSY.
- A request that is raised and then dropped while another requester owns the grant is lost. Requesters must hold `req` until they are granted.
- Simultaneous `done[o]` and timeout condition: this is a normal release, and `timeout` stays 0.
- `done[o]` in the first grant cycle is legal and gives a one-cycle ownership.
- Reset in the middle of a transaction: on the next edge `gnt`=0, `gnt_id`=0, `busy`=0, `timeout`=0, `ptr`=0, `hold_cnt`=0, state IDLE. In-flight ownership is discarded.
- `busy` is combinational from the registered `gnt`.

## Timing
- Arbitration latency: `req` sampled in IDLE at edge t gives `gnt` high after edge t+1.
- Release latency: a release condition sampled at edge t gives `gnt`=0 after edge t+1.
- There is one mandatory dead cycle (`gnt`=0) between consecutive grants. The next grant appears after edge t+2 if a request is pending.
- Ownership length is k cycles when `done` is asserted in the k-th grant cycle.
- With the timeout compiled in, ownership lasts at most MAX_HOLD cycles.
- `timeout` is high for exactly the one cycle in which `gnt` drops because of a timeout.
- `gnt` and `gnt_id` never change in the middle of a transaction; `gnt` is never multi-hot.

## Configuration
- `BURST_ARB_TIMEOUT_EN` defined: the MAX_HOLD timeout release and the `timeout` pulse are active.
- Undefined: the grant is held until `done[o]` or until `req[o]` drops. The port `timeout` is tied to 0. `hold_cnt` is still present, but it has no effect on release.

## Test plan
- Reset, then `req`=4'b1111 held and each owner asserts `done` in its 3rd grant cycle. Required: grants in the order 0,1,2,3,0. Each grant lasts 3 cycles, with one zero cycle between grants.
- `req`=4'b1010 with `ptr`=0. Required: grant to 1, then to 3, then back to 1, wrapping past the non-requesters.
- N=3, requester 2 granted and released. Required: `ptr`=0, and the next grant goes to 0 when `req`=3'b111.
- Timeout build, MAX_HOLD=4, owner never asserts `done`. Required: `gnt` high for 4 cycles, then `timeout`=1 for one cycle together with `gnt`=0. Same stimulus with `done` in cycle 4: `timeout`=0.
- Owner drops `req` in the middle of a transaction while a non-owner pulses `done`. Required: release one cycle after the drop, and the non-owner's `done` has no effect.
- `rst` asserted during grant cycle 2. Required: all outputs 0 after that edge; the next request is arbitrated from index 0.

Source files
------------

// File: rtl/burst_rr_arbiter_if.sv
// burst_rr_arbiter_if: requester-side handshake bundle between requesters and the burst round-robin arbiter
interface burst_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req;
  logic [N-1:0]   done;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           busy;
  logic           timeout;
  modport master (output req, done, input gnt, gnt_id, busy, timeout);
  modport slave  (input req, done, output gnt, gnt_id, busy, timeout);
endinterface

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: transaction-holding round-robin arbiter; define BURST_ARB_TIMEOUT_EN to enable MAX_HOLD timeout release
module burst_rr_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  parameter int IDW      = $clog2(N)
) (
  input logic clk,
  input logic rst,
  burst_rr_arbiter_if.slave bus
);
  localparam int HW = $clog2(MAX_HOLD + 1);
  typedef enum logic {IDLE, BUSY} state_e;
  state_e         state_q, state_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic [IDW-1:0] id_q, id_d, ptr_q, ptr_d, win;
  logic [HW-1:0]  hold_q, hold_d;
  logic           to_q, to_d, found, to_hit, own_done, own_req, rel;
  logic [IDW:0]   j;
  // Search upward from ptr with an explicit wrap so non-power-of-two N works
  always_comb begin
    win   = '0;
    found = 1'b0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j = {1'b0, ptr_q} + (IDW+1)'(i);
      j = (j >= (IDW+1)'(N)) ? j - (IDW+1)'(N) : j;
      if (!found && bus.req[j[IDW-1:0]]) begin
        found = 1'b1;
        win   = j[IDW-1:0];
      end
    end
  end
  assign own_done = bus.done[id_q];
  assign own_req  = bus.req[id_q];
`ifdef BURST_ARB_TIMEOUT_EN
  assign to_hit = hold_q == HW'(MAX_HOLD);
`else
  assign to_hit = 1'b0;
`endif
  assign rel = own_done | ~own_req | to_hit;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    hold_d  = hold_q;
    to_d    = 1'b0;
    if (state_q == IDLE) begin
      if (found) begin
        state_d = BUSY;
        gnt_d   = N'(1) << win;
        id_d    = win;
        hold_d  = HW'(1);
      end
    end else if (rel) begin
      state_d = IDLE;
      gnt_d   = '0;
      ptr_d   = (id_q == IDW'(N-1)) ? '0 : id_q + 1'b1;
      to_d    = to_hit & own_req & ~own_done;
    end else begin
      hold_d = (hold_q == HW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      id_q    <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
    end
  end
  assign bus.gnt     = gnt_q;
  assign bus.gnt_id  = id_q;
  assign bus.busy    = |gnt_q;
  assign bus.timeout = to_q;
endmodule
